read_data_pool: RTL and testbench



---
 rtl/read_data_pool.sv | 217 +++++++++++++++++++++
 tb/tb_read_data_pool.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/read_data_pool.sv
// read_data_pool: queues issued reads, assembles returning DQ beats into 64-bit words
// and hands them to the host in issue order. Optional watchdog: RPOOL_TIMEOUT_EN.
module read_data_pool #(
  parameter int DEPTH          = 8,
  parameter int LOG2_DEPTH     = 3,
  parameter int DATA_SIZE      = 64,
  parameter int ADDR_SIZE      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_issued,
  input  logic [ADDR_SIZE-1:0] raddr,
  input  logic [1:0]           rburst_size,
  input  logic                 dq_valid,
  input  logic [7:0]           dq_data,
  input  logic                 rready,
  output logic                 rvalid,
  output logic [DATA_SIZE-1:0] pool_rdata,
  output logic [ADDR_SIZE-1:0] pool_raddr,
  output logic [1:0]           pool_rburst_size,
  output logic                 rfull,
  output logic                 rerr
);
  localparam int CW = LOG2_DEPTH + 2;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [LOG2_DEPTH-1:0] PTR_ONE = LOG2_DEPTH'(1);
  localparam logic [LOG2_DEPTH:0]   CNT_ONE = (LOG2_DEPTH + 1)'(1);

  if (DEPTH != 2**LOG2_DEPTH) begin : g_bad_depth
    $error("read_data_pool: DEPTH must equal 2**LOG2_DEPTH");
  end
  if (DATA_SIZE != 64) begin : g_bad_width
    $error("read_data_pool: DATA_SIZE must be 64 (8 beats of 8 bits)");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("read_data_pool: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, COLLECT, PUSH} state_t;
  state_t state, state_next;

  logic [ADDR_SIZE-1:0]  pend_addr [DEPTH];
  logic [1:0]            pend_size [DEPTH];
  logic [LOG2_DEPTH-1:0] pend_wr, pend_rd;
  logic [LOG2_DEPTH:0]   pend_cnt;

  logic [DATA_SIZE-1:0]  comp_data [DEPTH];
  logic [ADDR_SIZE-1:0]  comp_addr [DEPTH];
  logic [1:0]            comp_size [DEPTH];
  logic [LOG2_DEPTH-1:0] comp_wr, comp_rd;
  logic [LOG2_DEPTH:0]   comp_cnt;

  logic [ADDR_SIZE-1:0]  work_addr;
  logic [1:0]            work_size;
  logic [DATA_SIZE-1:0]  work_data;
  logic [2:0]            beat;

  logic [CW-1:0] occupancy;
  logic accept, drop, take_head, take_bypass, push_pend;
  logic beat_in, last_beat, stray, do_push, load_out, timeout_hit;

  function automatic logic [2:0] last_index(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  // The output register holds one completed entry, so it counts toward occupancy.
  assign occupancy = CW'(pend_cnt) + CW'(comp_cnt) + CW'(rvalid) + CW'(state != IDLE);
  assign rfull     = (occupancy == DEPTH_C);
  assign accept    = read_issued && !rfull;
  assign drop      = read_issued && rfull;
  assign do_push   = (state == PUSH);
  assign load_out  = (comp_cnt != '0) && (!rvalid || rready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take_head || take_bypass) state_next = COLLECT;
      COLLECT: begin
        if (last_beat)        state_next = PUSH;
        else if (timeout_hit) state_next = IDLE;
      end
      PUSH:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An idle assembler with nothing pending takes a fresh command straight from the
  // issue port, so its first beat may arrive on the very next cycle.
  always_comb begin
    take_head   = 1'b0;
    take_bypass = 1'b0;
    beat_in     = 1'b0;
    last_beat   = 1'b0;
    stray       = 1'b0;
    case (state)
      IDLE: begin
        take_head   = (pend_cnt != '0);
        take_bypass = (pend_cnt == '0) && accept;
        stray       = dq_valid;
      end
      COLLECT: begin
        beat_in   = dq_valid;
        last_beat = dq_valid && (beat == last_index(work_size));
      end
      default: stray = dq_valid;
    endcase
    push_pend = accept && !take_bypass;
  end

`ifdef RPOOL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] stall_cnt;

  assign timeout_hit = (state == COLLECT) && !dq_valid &&
                       (stall_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             stall_cnt <= '0;
    else if (state != COLLECT || dq_valid) stall_cnt <= '0;
    else                                 stall_cnt <= stall_cnt + TW'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_addr <= '0;
      work_size <= '0;
      work_data <= '0;
      beat      <= '0;
    end else if (take_head) begin
      work_addr <= pend_addr[pend_rd];
      work_size <= pend_size[pend_rd];
      work_data <= '0;
      beat      <= '0;
    end else if (take_bypass) begin
      work_addr <= raddr;
      work_size <= rburst_size;
      work_data <= '0;
      beat      <= '0;
    end else if (beat_in) begin
      work_data[{beat, 3'b000} +: 8] <= dq_data;
      beat <= beat + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_pend) begin
      pend_addr[pend_wr] <= raddr;
      pend_size[pend_wr] <= rburst_size;
    end
    if (do_push) begin
      comp_data[comp_wr] <= work_data;
      comp_addr[comp_wr] <= work_addr;
      comp_size[comp_wr] <= work_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_wr  <= '0;
      pend_rd  <= '0;
      pend_cnt <= '0;
      comp_wr  <= '0;
      comp_rd  <= '0;
      comp_cnt <= '0;
    end else begin
      if (push_pend) pend_wr <= pend_wr + PTR_ONE;
      if (take_head) pend_rd <= pend_rd + PTR_ONE;
      case ({push_pend, take_head})
        2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
        2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
        default: pend_cnt <= pend_cnt;
      endcase
      if (do_push)  comp_wr <= comp_wr + PTR_ONE;
      if (load_out) comp_rd <= comp_rd + PTR_ONE;
      case ({do_push, load_out})
        2'b10:   comp_cnt <= comp_cnt + CNT_ONE;
        2'b01:   comp_cnt <= comp_cnt - CNT_ONE;
        default: comp_cnt <= comp_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid           <= 1'b0;
      pool_rdata       <= '0;
      pool_raddr       <= '0;
      pool_rburst_size <= '0;
      rerr             <= 1'b0;
    end else begin
      if (load_out) begin
        rvalid           <= 1'b1;
        pool_rdata       <= comp_data[comp_rd];
        pool_raddr       <= comp_addr[comp_rd];
        pool_rburst_size <= comp_size[comp_rd];
      end else if (rready) begin
        rvalid <= 1'b0;
      end
      rerr <= drop || stray || timeout_hit;
    end
  end

endmodule

// File: tb/tb_read_data_pool.sv
// Directed self-checking bench for read_data_pool; the watchdog test is compiled
// only when RPOOL_TIMEOUT_EN is defined.
module tb_read_data_pool;
  logic        clk;
  logic        rst;
  logic        read_issued;
  logic [7:0]  raddr;
  logic [1:0]  rburst_size;
  logic        dq_valid;
  logic [7:0]  dq_data;
  logic        rready;
  logic        rvalid;
  logic [63:0] pool_rdata;
  logic [7:0]  pool_raddr;
  logic [1:0]  pool_rburst_size;
  logic        rfull;
  logic        rerr;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [73:0] got_q[$];
  logic [73:0] exp_q[$];

  read_data_pool dut (
    .clk              (clk),
    .rst              (rst),
    .read_issued      (read_issued),
    .raddr            (raddr),
    .rburst_size      (rburst_size),
    .dq_valid         (dq_valid),
    .dq_data          (dq_data),
    .rready           (rready),
    .rvalid           (rvalid),
    .pool_rdata       (pool_rdata),
    .pool_raddr       (pool_raddr),
    .pool_rburst_size (pool_rburst_size),
    .rfull            (rfull),
    .rerr             (rerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after each rising edge, so the falling edge sees the handshake.
  always @(negedge clk) begin
    if (!rst && rvalid && rready) got_q.push_back({pool_raddr, pool_rburst_size, pool_rdata});
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic iss, input logic [7:0] a, input logic [1:0] s,
                               input logic dv, input logic [7:0] d, input logic rdy);
    read_issued = iss;
    raddr       = a;
    rburst_size = s;
    dq_valid    = dv;
    dq_data     = d;
    rready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, 8'h00, rdy);
  endtask

  // Beats for the command in COLLECT, then two quiet cycles (PUSH, IDLE pop).
  task automatic serveCmd(input logic [1:0] s, input logic [7:0] seed, input logic [7:0] step,
                          input logic rdy, output logic [63:0] data);
    logic [7:0] b;
    data = '0;
    for (int j = 0; j < (1 << s); j++) begin
      b = seed + step * 8'(j);
      data[8*j +: 8] = b;
      applyStimulus(1'b0, 8'h00, 2'd0, 1'b1, b, rdy);
    end
    idleCycles(2, rdy);
  endtask

  task automatic drainAndCompare(input string tag, input int budget);
    logic [73:0] g, e;
    int cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < budget) begin
      idleCycles(1, 1'b1);
      cyc++;
    end
    idleCycles(2, 1'b1);
    checkOutput($sformatf("%s_count", tag), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      g = got_q[i];
      e = exp_q[i];
      checkOutput($sformatf("%s%0d_addr", tag, i), 64'(g[73:66]), 64'(e[73:66]));
      checkOutput($sformatf("%s%0d_size", tag, i), 64'(g[65:64]), 64'(e[65:64]));
      checkOutput($sformatf("%s%0d_data", tag, i), g[63:0], e[63:0]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [63:0] d;
    logic [7:0]  a;
    logic [1:0]  s;
    int          pulses;

    rst = 1'b1;
    read_issued = 1'b0; raddr = '0; rburst_size = '0;
    dq_valid = 1'b0; dq_data = '0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_rfull", 64'(rfull), 64'd0);
    checkOutput("rst_rerr", 64'(rerr), 64'd0);
    checkOutput("rst_rdata", pool_rdata, 64'd0);
    checkOutput("rst_raddr", 64'(pool_raddr), 64'd0);
    checkOutput("rst_size", 64'(pool_rburst_size), 64'd0);

    // 8-beat read: rvalid appears exactly 3 cycles after the last beat
    applyStimulus(1'b1, 8'h10, 2'd3, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 2'd0, 1'b1, 8'((i + 1) * 17), 1'b0);
    checkOutput("t1_rvalid_plus1", 64'(rvalid), 64'd0);
    idleCycles(1, 1'b0);
    checkOutput("t1_rvalid_plus2", 64'(rvalid), 64'd0);
    idleCycles(1, 1'b0);
    checkOutput("t1_rvalid_plus3", 64'(rvalid), 64'd1);
    checkOutput("t1_rdata", pool_rdata, 64'h8877665544332211);
    checkOutput("t1_raddr", 64'(pool_raddr), 64'h10);
    checkOutput("t1_size", 64'(pool_rburst_size), 64'd3);
    checkOutput("t1_rerr", 64'(rerr), 64'd0);
    idleCycles(2, 1'b0);
    checkOutput("t1_hold_rdata", pool_rdata, 64'h8877665544332211);
    idleCycles(1, 1'b1);
    checkOutput("t1_popped", 64'(rvalid), 64'd0);
    got_q.delete();

    // Two commands of different sizes, answered in order
    applyStimulus(1'b1, 8'h01, 2'd0, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h02, 2'd1, 1'b0, 8'h00, 1'b1);
    serveCmd(2'd0, 8'hAA, 8'h00, 1'b1, d);
    serveCmd(2'd1, 8'hBB, 8'h11, 1'b1, d);
    exp_q.push_back({8'h01, 2'd0, 64'h00000000000000AA});
    exp_q.push_back({8'h02, 2'd1, 64'h000000000000CCBB});
    drainAndCompare("t2_resp", 30);

    // Fill to capacity, then a dropped ninth issue
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'(8'h30 + i), 2'd0, 1'b0, 8'h00, 1'b1);
    checkOutput("t3_rfull", 64'(rfull), 64'd1);
    applyStimulus(1'b1, 8'h99, 2'd0, 1'b0, 8'h00, 1'b1);
    checkOutput("t3_drop_rerr", 64'(rerr), 64'd1);
    checkOutput("t3_still_full", 64'(rfull), 64'd1);
    idleCycles(1, 1'b1);
    checkOutput("t3_rerr_clear", 64'(rerr), 64'd0);
    for (int i = 0; i < 8; i++) begin
      serveCmd(2'd0, 8'(8'hC0 + i), 8'h00, 1'b1, d);
      exp_q.push_back({8'(8'h30 + i), 2'd0, 64'(8'hC0 + i)});
    end
    drainAndCompare("t3_resp", 40);

    // Stray beat while idle
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b1, 8'h5A, 1'b1);
    checkOutput("t4_stray_rerr", 64'(rerr), 64'd1);
    idleCycles(1, 1'b1);
    checkOutput("t4_rerr_clear", 64'(rerr), 64'd0);
    idleCycles(6, 1'b1);
    checkOutput("t4_no_resp", 64'(got_q.size()), 64'd0);
    checkOutput("t4_rvalid", 64'(rvalid), 64'd0);

    // Backpressure, pop+issue in one cycle, then refill to full
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h20 + i), 2'd0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      serveCmd(2'd0, 8'(8'hD0 + i), 8'h00, 1'b0, d);
      exp_q.push_back({8'(8'h20 + i), 2'd0, 64'(8'hD0 + i)});
    end
    idleCycles(3, 1'b0);
    checkOutput("t5_rvalid", 64'(rvalid), 64'd1);
    checkOutput("t5_head_addr", 64'(pool_raddr), 64'h20);
    checkOutput("t5_head_data", pool_rdata, 64'hD0);
    checkOutput("t5_rfull", 64'(rfull), 64'd0);
    idleCycles(3, 1'b0);
    checkOutput("t5_stable_addr", 64'(pool_raddr), 64'h20);
    checkOutput("t5_stable_data", pool_rdata, 64'hD0);
    applyStimulus(1'b1, 8'h23, 2'd0, 1'b0, 8'h00, 1'b1);
    checkOutput("t5_next_addr", 64'(pool_raddr), 64'h21);
    checkOutput("t5_next_rvalid", 64'(rvalid), 64'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h24 + i), 2'd0, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_seven_rfull", 64'(rfull), 64'd0);
    applyStimulus(1'b1, 8'h28, 2'd0, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_eight_rfull", 64'(rfull), 64'd1);
    for (int i = 3; i < 9; i++) begin
      serveCmd(2'd0, 8'(8'hD0 + i), 8'h00, 1'b1, d);
      exp_q.push_back({8'(8'h20 + i), 2'd0, 64'(8'hD0 + i)});
    end
    drainAndCompare("t5_resp", 40);

    // Twelve mixed-size pairs
    for (int i = 0; i < 12; i++) begin
      a = 8'(8'h40 + i);
      s = 2'(i % 4);
      applyStimulus(1'b1, a, s, 1'b0, 8'h00, 1'b1);
      serveCmd(s, 8'(16 * i + 1), 8'h01, 1'b1, d);
      exp_q.push_back({a, s, d});
    end
    drainAndCompare("t6_resp", 40);

`ifdef RPOOL_TIMEOUT_EN
    applyStimulus(1'b1, 8'h50, 2'd2, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b1, 8'hE1, 1'b1);
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      idleCycles(1, 1'b1);
      if (rerr) pulses++;
    end
    checkOutput("to_rerr_pulses", 64'(pulses), 64'd1);
    checkOutput("to_no_resp", 64'(got_q.size()), 64'd0);
    checkOutput("to_rfull", 64'(rfull), 64'd0);
`else
    pulses = 0;
`endif

    // Occupancy back to zero: seven fit, the eighth fills; then async reset mid-burst
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h70 + i), 2'd1, 1'b0, 8'h00, 1'b0);
    checkOutput("t7_seven_rfull", 64'(rfull), 64'd0);
    applyStimulus(1'b0, 8'h00, 2'd0, 1'b1, 8'h77, 1'b0);
    applyStimulus(1'b1, 8'h77, 2'd1, 1'b0, 8'h00, 1'b0);
    checkOutput("t7_eight_rfull", 64'(rfull), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t7_async_rfull", 64'(rfull), 64'd0);
    checkOutput("t7_async_rvalid", 64'(rvalid), 64'd0);
    read_issued = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
    applyStimulus(1'b1, 8'h7F, 2'd1, 1'b0, 8'h00, 1'b1);
    serveCmd(2'd1, 8'hE0, 8'h01, 1'b1, d);
    exp_q.push_back({8'h7F, 2'd1, 64'h000000000000E1E0});
    drainAndCompare("t7_resp", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got 0x0, expected 0x1");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
